// File: rtl/alu_result_stage.sv
// alu_result_stage: registered FIFO stage behind the 64-bit ALU, with sticky flags and a saturating op counter
module alu_result_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_sel,
  input  logic [63:0]              in_result,
  input  logic [63:0]              in_upper,
  input  logic [6:0]               in_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [5:0]               out_sel,
  output logic [63:0]              out_result,
  output logic [63:0]              out_upper,
  output logic [6:0]               out_flags,
  input  logic                     stat_clr,
  output logic [6:0]               sticky_flags,
  output logic [CNT_W-1:0]         op_count,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 6 + 64 + 64 + 7;
  logic [EW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic [6:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             push, pop;
  // in_ready depends only on registered occupancy, so a full FIFO refuses even when popping
  assign in_ready     = level_q != LW'(DEPTH);
  assign out_valid    = level_q != '0;
  assign push         = in_valid && in_ready;
  assign pop          = out_valid && out_ready;
  assign {out_sel, out_result, out_upper, out_flags} = mem_q[rd_ptr_q];
  assign sticky_flags = sticky_q;
  assign op_count     = cnt_q;
  assign level        = level_q;
  // clear takes effect before a coincident push is accounted
  always_comb begin
    level_d  = level_q + LW'(push) - LW'(pop);
    sticky_d = (stat_clr ? '0 : sticky_q) | (push ? in_flags : '0);
    cnt_base = stat_clr ? '0 : cnt_q;
    cnt_d    = (push && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_sel, in_result, in_upper, in_flags};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q  <= level_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: vector table, hand sequences and random run against a queue model
module tb_alu_result_stage;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam logic [63:0] K = 64'h1234_BCDE_BA98_8765;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, stat_clr;
  logic [5:0] in_sel, out_sel;
  logic [63:0] in_result, in_upper, out_result, out_upper;
  logic [6:0] in_flags, out_flags, sticky_flags;
  logic [CNT_W-1:0] op_count;
  logic [2:0] level;
  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_result(in_result), .in_upper(in_upper), .in_flags(in_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_sel(out_sel), .out_result(out_result), .out_upper(out_upper),
    .out_flags(out_flags), .stat_clr(stat_clr), .sticky_flags(sticky_flags),
    .op_count(op_count), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv, ordy, clr;
    logic [5:0] sel;
    logic [6:0] fl;
    logic ov;
    logic [2:0] lvl;
    logic ir;
    logic [5:0] hsel;
    logic [6:0] stk;
    logic [2:0] cnt;
  } vec_t;

  typedef struct {
    logic [5:0] s;
    logic [63:0] r, u;
    logic [6:0] f;
  } ent_t;

  vec_t vt[17];
  ent_t q[$];
  logic [6:0] m_stk;
  int m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic clr, input logic [5:0] sel,
                       input logic [6:0] fl);
    in_valid  = iv;
    out_ready = ordy;
    stat_clr  = clr;
    in_sel    = sel;
    in_result = K ^ 64'(sel);
    in_upper  = ~(K ^ 64'(sel));
    in_flags  = fl;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    chk("m_out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("m_level", 64'(level), 64'(q.size()));
    chk("m_in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("m_sticky", 64'(sticky_flags), 64'(m_stk));
    chk("m_op_count", 64'(op_count), 64'(m_cnt));
    if (q.size() != 0) begin
      chk("m_out_sel", 64'(out_sel), 64'(q[0].s));
      chk("m_out_result", out_result, q[0].r);
      chk("m_out_upper", out_upper, q[0].u);
      chk("m_out_flags", 64'(out_flags), 64'(q[0].f));
    end
  endtask

  initial begin
    vt[0]  = '{1, 1, 0, 0, 7'h00, 1, 1, 1, 0, 7'h00, 1};
    vt[1]  = '{0, 1, 0, 0, 7'h00, 0, 0, 1, 0, 7'h00, 1};
    vt[2]  = '{1, 0, 1, 1, 7'h00, 1, 1, 1, 1, 7'h00, 1};
    vt[3]  = '{1, 0, 0, 2, 7'h00, 1, 2, 1, 1, 7'h00, 2};
    vt[4]  = '{1, 0, 0, 3, 7'h00, 1, 3, 1, 1, 7'h00, 3};
    vt[5]  = '{1, 0, 0, 4, 7'h00, 1, 4, 0, 1, 7'h00, 4};
    vt[6]  = '{1, 0, 0, 5, 7'h00, 1, 4, 0, 1, 7'h00, 4};
    vt[7]  = '{1, 1, 0, 5, 7'h00, 1, 3, 1, 2, 7'h00, 4};
    vt[8]  = '{1, 0, 0, 5, 7'h00, 1, 4, 0, 2, 7'h00, 5};
    vt[9]  = '{0, 1, 0, 0, 7'h00, 1, 3, 1, 3, 7'h00, 5};
    vt[10] = '{0, 1, 0, 0, 7'h00, 1, 2, 1, 4, 7'h00, 5};
    vt[11] = '{0, 1, 0, 0, 7'h00, 1, 1, 1, 5, 7'h00, 5};
    vt[12] = '{0, 1, 0, 0, 7'h00, 0, 0, 1, 0, 7'h00, 5};
    vt[13] = '{1, 1, 0, 6, 7'h01, 1, 1, 1, 6, 7'h01, 6};
    vt[14] = '{1, 1, 0, 7, 7'h04, 1, 1, 1, 7, 7'h05, 7};
    vt[15] = '{1, 1, 1, 8, 7'h40, 1, 1, 1, 8, 7'h40, 1};
    vt[16] = '{0, 1, 1, 0, 7'h00, 0, 0, 1, 0, 7'h00, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_sticky", 64'(sticky_flags), 0);
    chk("rst_op_count", 64'(op_count), 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].iv, vt[i].ordy, vt[i].clr, vt[i].sel, vt[i].fl);
      cycle();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vt[i].ov));
      chk($sformatf("v%0d_level", i), 64'(level), 64'(vt[i].lvl));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vt[i].ir));
      chk($sformatf("v%0d_sticky", i), 64'(sticky_flags), 64'(vt[i].stk));
      chk($sformatf("v%0d_op_count", i), 64'(op_count), 64'(vt[i].cnt));
      if (vt[i].ov) begin
        chk($sformatf("v%0d_out_sel", i), 64'(out_sel), 64'(vt[i].hsel));
        chk($sformatf("v%0d_out_result", i), out_result, K ^ 64'(vt[i].hsel));
        chk($sformatf("v%0d_out_upper", i), out_upper, ~(K ^ 64'(vt[i].hsel)));
      end
    end

    // counter saturation: ten accepted pushes, one in flight at a time
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0, 6'(i + 10), 7'h00);
      cycle();
      chk($sformatf("sat%0d_op_count", i), 64'(op_count), 64'((i + 1 > 7) ? 7 : i + 1));
      chk($sformatf("sat%0d_out_sel", i), 64'(out_sel), 64'(i + 10));
    end
    drive(0, 1, 0, 0, 0);
    cycle();
    chk("sat_final_op_count", 64'(op_count), 7);
    chk("sat_final_level", 64'(level), 0);

    // async reset with three entries queued
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 6'(i + 40), 7'h7f);
      cycle();
    end
    chk("pre_rst_level", 64'(level), 3);
    chk("pre_rst_sticky", 64'(sticky_flags), 64'h7f);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_level", 64'(level), 0);
    chk("arst_sticky", 64'(sticky_flags), 0);
    chk("arst_op_count", 64'(op_count), 0);
    chk("arst_out_result", out_result, 0);
    #2;
    rst = 1'b0;
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("post_rst%0d_out_valid", i), 64'(out_valid), 0);
      chk($sformatf("post_rst%0d_in_ready", i), 64'(in_ready), 1);
    end

    // random traffic against the queue model, with shifting bias to reach full and empty
    m_stk = '0;
    m_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      logic iv, ordy, clr, mpush, mpop;
      ent_t e;
      int bias;
      bias = (c / 250) % 3;
      iv   = $urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2));
      ordy = $urandom_range(0, 3) < (bias == 0 ? 1 : (bias == 1 ? 3 : 2));
      clr  = $urandom_range(0, 15) == 0;
      e.s  = 6'($urandom);
      e.r  = {$urandom, $urandom};
      e.u  = {$urandom, $urandom};
      e.f  = 7'($urandom);
      in_valid  = iv;
      out_ready = ordy;
      stat_clr  = clr;
      in_sel    = e.s;
      in_result = e.r;
      in_upper  = e.u;
      in_flags  = e.f;
      mpush = iv && (q.size() < DEPTH);
      mpop  = ordy && (q.size() > 0);
      cycle();
      if (mpop) void'(q.pop_front());
      if (clr) begin
        m_stk = '0;
        m_cnt = 0;
      end
      if (mpush) begin
        q.push_back(e);
        m_stk = m_stk | e.f;
        if (m_cnt < 7) m_cnt++;
      end
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
Registered downstream stage for the combinational 64-bit ALU. It captures each ALU result, upper result, opcode and status flag set into a small FIFO with valid/ready handshakes on both sides. It also keeps sticky (accumulated) flags and a saturating operation counter for the control/debug path. It sits between the ALU outputs and the writeback/consumer logic, and decouples the consumer's stalls from the ALU issue side.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_W, 16, width of the accepted-operation counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU output word is valid this cycle
in_ready  output  1  stage can accept a word
in_sel  input  6  opcode that produced the word
in_result  input  64  ALU result
in_upper  input  64  ALU upper_result
in_flags  input  7  [0]carry [1]overflow [2]zero [3]negative [4]parity [5]modulo [6]sign
out_valid  output  1  head entry is valid
out_ready  input  1  consumer takes the head entry
out_sel  output  6  head opcode
out_result  output  64  head result
out_upper  output  64  head upper result
out_flags  output  7  head flags, same bit order as in_flags
stat_clr  input  1  clear sticky flags and counter (synchronous)
sticky_flags  output  7  OR of in_flags over all accepted words since reset or clear
op_count  output  CNT_W  number of accepted words, saturating
level  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (async, rst=1) sets all outputs to 0: out_valid=0, level=0, sticky_flags=0, op_count=0, out_* data=0. in_ready=1 from reset release.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- in_ready = (level != DEPTH). It is derived from registered state only. There is no combinational path from out_ready to in_ready.
- out_valid = (level != 0). out_* are driven from the head storage entry. They hold stable while out_valid && !out_ready.
- Latency: a word pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1 if the FIFO was empty. Otherwise it appears after all earlier entries have been popped. Ordering is strict FIFO.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both operations take effect.
- Full (level==DEPTH): push is refused (in_ready=0) even if a pop happens in the same cycle. in_ready rises the cycle after the pop.
- Empty: pop is impossible (out_valid=0). A push into an empty FIFO does not bypass to the output in the same cycle.
- Read/write pointers are $clog2(DEPTH) bits wide and wrap naturally modulo DEPTH. level is tracked separately.
- Sticky flags are updated on push: sticky_flags <= sticky_flags | in_flags.
- Counter is updated on push: op_count <= op_count+1, saturating at all-ones. It never wraps.
- stat_clr without push: sticky_flags<=0 and op_count<=0 next cycle.
- stat_clr in the same cycle as a push: clear is applied first, giving sticky_flags<=in_flags and op_count<=1.
- stat_clr does not affect FIFO contents, level or handshakes.
- Refused pushes (in_valid && !in_ready) do not change the sticky flags or the counter.
- Reset asserted mid-operation discards all entries immediately. out_valid drops asynchronously, and all statistics are cleared.
- Data inputs are don't-care when in_valid=0. X on unused inputs must not propagate into storage.

Test Plan:
1. Basic pass-through: reset, out_ready=1, push sel=0, result=64'h1234_BCDE_BA98_8765, upper=0, flags=7'b0000000. Required response: out_valid=1 one cycle later with identical data, level returns to 0 after the pop, op_count=1.
2. Fill and back-pressure: out_ready=0, push sel=1..5 on consecutive cycles with DEPTH=4. Required response: in_ready=0 after the 4th accept, level=4, the sel=5 word is held and not counted (op_count=4). Raise out_ready: out_sel is 1,2,3,4 in order, and in_ready=1 the cycle after the first pop.
3. Full with simultaneous pop: level=4, in_valid=1 and out_ready=1 in the same cycle. Required response: push refused, level=3, then the push is accepted on the next cycle to give level=4.
4. Sticky and clear: push flags 7'b0000001 then 7'b0000100. Required response: sticky_flags=7'b0000101. Then stat_clr together with a push of flags 7'b1000000. Required response: sticky_flags=7'b1000000, op_count=1.
5. Counter saturation with CNT_W=3: do 10 accepted pushes with out_ready=1. Required response: op_count=7, with no wrap.
6. Async reset mid-stream: level=3, assert rst between clock edges. Required response: out_valid=0 and level=0 immediately, sticky_flags=0, op_count=0, in_ready=1 after release, and old data is never re-emitted.
